seq_control: RTL
================

SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 Parameter DataWidth, default 8: width of IR input and instruction-count output.
REQ-002 Parameter SelectSize, default 2: width of ADDR_Src output.
REQ-003 Clk  input  1: single clock; all state changes on rising edge.
REQ-004 Reset  input  1: reset, asynchronous, active-low.
REQ-005 IR  input  DataWidth: current instruction register contents; opcode = IR[7:4].
REQ-006 Resume  input  1: active-high; leaves HALT.
REQ-007 PC_Ld  output  1: PC load, active-low.
REQ-008 PC_Inc  output  1: PC increment, active-low.
REQ-009 IR_Ld  output  1: IR load, active-low.
REQ-010 DR_Ld  output  1: operand data register load, active-low.
REQ-011 MEM_En  output  1: memory enable, active-low.
REQ-012 MEM_RW  output  1: 1 = read, 0 = write; constant 1 in this block.
REQ-013 ADDR_Src  output  SelectSize: address mux select; 0 = PC.
REQ-014 Halted  output  1: high while in HALT.
REQ-015 Illegal  output  1: one-cycle high pulse on an undefined opcode.
REQ-016 State  output  3: current state encoding, for debug.
REQ-017 InstrCount  output  DataWidth: count of retired instructions.

Function
REQ-018 Encodings: IDLE=0, FETCH1=1, FETCH2=2, DECODE=3, OPER1=4, OPER2=5, HALT=6; code 7 unreachable and SHALL go to IDLE.
REQ-019 Opcodes: 0x0 NOP, 0x1 LDI (one operand byte), 0x2 JMP (one operand byte = target), 0x3 HLT; 0x4-0xF illegal.
REQ-020 Outputs are Moore (state only), except Illegal and the DECODE transition, which also depend on IR.
REQ-021 Default in every state: PC_Ld, PC_Inc, IR_Ld, DR_Ld, MEM_En = 1 (inactive); ADDR_Src = 0; MEM_RW = 1; Halted = 0; Illegal = 0.
REQ-022 IDLE: no active controls; next state FETCH1.
REQ-023 FETCH1: MEM_En = 0 (synchronous memory read at PC); next FETCH2.
REQ-024 FETCH2: MEM_En = 0, IR_Ld = 0, PC_Inc = 0; next DECODE.
REQ-025 DECODE, NOP: InstrCount increments; next FETCH1.
REQ-026 DECODE, HLT: InstrCount increments; next HALT.
REQ-027 DECODE, LDI or JMP: next OPER1.
REQ-028 DECODE, illegal opcode: Illegal = 1 for this cycle; InstrCount unchanged; next FETCH1.
REQ-029 OPER1: MEM_En = 0 (operand read at PC); next OPER2.
REQ-030 OPER2, LDI: MEM_En = 0, DR_Ld = 0, PC_Inc = 0; InstrCount increments; next FETCH1.
REQ-031 OPER2, JMP: MEM_En = 0, PC_Ld = 0 (PC takes memory data); PC_Inc stays 1; InstrCount increments; next FETCH1.
REQ-032 IR is stable from DECODE through OPER2, because IR_Ld is asserted only in FETCH2.
REQ-033 HALT: Halted = 1, no active controls; stays in HALT while Resume = 0; goes to FETCH1 on the edge where Resume = 1.
REQ-034 Resume is ignored in every state except HALT.
REQ-035 InstrCount is modulo 2^DataWidth and wraps from all-ones to 0 with no flag.
REQ-036 PC_Ld and PC_Inc are never both 0 in the same cycle.
REQ-037 Cycle counts: NOP = 3 cycles (FETCH1 to FETCH1), LDI/JMP = 5 cycles, illegal = 3 cycles.

Reset
REQ-038 Reset = 0 takes effect immediately, without a clock, in any state including mid-OPER2.
REQ-039 During reset: State = IDLE; all active-low controls = 1; ADDR_Src = 0; Halted = 0; Illegal = 0; InstrCount = 0.
REQ-040 After reset deasserts: first rising edge moves IDLE to FETCH1.

Verification
REQ-041 Reset release, IR = 0x00 held -> State sequence 0,1,2,3,1,2,3; InstrCount increments once per pass through DECODE.
REQ-042 LDI: IR = 0x1x at DECODE -> states 3,4,5,1; DR_Ld = 0 and PC_Inc = 0 only in state 5; InstrCount +1.
REQ-043 JMP: IR = 0x2x -> in state 5, PC_Ld = 0 and PC_Inc = 1; next state 1; no cycle has PC_Ld = 0 and PC_Inc = 0.
REQ-044 HLT: IR = 0x30 -> enters HALT with Halted = 1; held 10 cycles with Resume = 0 and stays there; Resume = 1 for one cycle -> next state 1, Halted = 0.
REQ-045 Illegal: IR = 0x50 -> Illegal = 1 exactly in the DECODE cycle; InstrCount unchanged; next state 1.
REQ-046 Asynchronous reset asserted mid-cycle in OPER2 with InstrCount = 0xFF preset by 255 NOPs -> outputs reach reset values before the next edge, InstrCount = 0; a separate run confirms 256 NOPs wrap InstrCount to 0x00.

Source files
------------

// File: rtl/seq_control.sv
// Instruction sequencer for a tiny byte-wide CPU: fetch, decode, and one-operand
// execute phases, with halt/resume, illegal-opcode flagging and a retired-instruction counter.
module seq_control #(
  parameter int DataWidth  = 8,
  parameter int SelectSize = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DataWidth-1:0]  IR,
  input  logic                  Resume,
  output logic                  PC_Ld,
  output logic                  PC_Inc,
  output logic                  IR_Ld,
  output logic                  DR_Ld,
  output logic                  MEM_En,
  output logic                  MEM_RW,
  output logic [SelectSize-1:0] ADDR_Src,
  output logic                  Halted,
  output logic                  Illegal,
  output logic [2:0]            State,
  output logic [DataWidth-1:0]  InstrCount
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    DECODE = 3'd3,
    OPER1  = 3'd4,
    OPER2  = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_HLT = 4'h3;

  state_t     state;
  state_t     next_state;
  logic [3:0] opcode;
  logic       retire;
  logic       ir_unused;

  assign opcode    = IR[7:4];
  // Only the opcode nibble steers sequencing; the remaining IR bits are operand payload.
  assign ir_unused = ^(IR & ~DataWidth'(8'hF0));
  assign State     = state;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)      InstrCount <= '0;
    else if (retire) InstrCount <= InstrCount + DataWidth'(1);
  end

  always_comb begin
    next_state = IDLE;
    PC_Ld      = 1'b1;
    PC_Inc     = 1'b1;
    IR_Ld      = 1'b1;
    DR_Ld      = 1'b1;
    MEM_En     = 1'b1;
    MEM_RW     = 1'b1;
    ADDR_Src   = '0;
    Halted     = 1'b0;
    Illegal    = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: next_state = FETCH1;
      FETCH1: begin
        MEM_En     = 1'b0;
        next_state = FETCH2;
      end
      FETCH2: begin
        MEM_En     = 1'b0;
        IR_Ld      = 1'b0;
        PC_Inc     = 1'b0;
        next_state = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_NOP: begin
            retire     = 1'b1;
            next_state = FETCH1;
          end
          OP_HLT: begin
            retire     = 1'b1;
            next_state = HALT;
          end
          OP_LDI, OP_JMP: next_state = OPER1;
          default: begin
            Illegal    = 1'b1;
            next_state = FETCH1;
          end
        endcase
      end
      OPER1: begin
        MEM_En     = 1'b0;
        next_state = OPER2;
      end
      OPER2: begin
        MEM_En     = 1'b0;
        retire     = 1'b1;
        next_state = FETCH1;
        // A jump replaces the PC outright, so it must not also increment it.
        if (opcode == OP_JMP) begin
          PC_Ld = 1'b0;
        end else begin
          DR_Ld  = 1'b0;
          PC_Inc = 1'b0;
        end
      end
      HALT: begin
        Halted     = 1'b1;
        next_state = Resume ? FETCH1 : HALT;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
